// File: rtl/cs_approx_avg_win.sv
// Streaming approximate-average filter over a sliding window of the last WIN samples.
// Latency: sample accepted at edge k -> Y/out_valid registered at edge k+1.
// No backpressure: in_valid qualifies each sample, out_valid pulses once per full-window accept.
module cs_approx_avg_win #(
  parameter int DW    = 8,
  parameter int WIN   = 9,
  parameter int SHIFT = 3,
  parameter int OW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [DW-1:0] X,
  input  logic          mode,
  output logic          out_valid,
  output logic [OW-1:0] Y
);

  // Sum needs DW + clog2(WIN) bits; the fill counter must reach WIN itself.
  localparam int SW = DW + $clog2(WIN);
  localparam int CW = $clog2(WIN + 1);
  localparam logic [SW-1:0] WIN_S  = SW'(WIN);
  localparam logic [SW:0]   WIN_S1 = (SW + 1)'(WIN);
  localparam logic [CW-1:0] WIN_C  = CW'(WIN);
  localparam longint MAX_Y = (longint'(2) * WIN * ((longint'(1) << DW) - 1)) >> SHIFT;

  // Reject parameter sets the datapath cannot represent.
  generate
    if (WIN < 2 || WIN > 32) begin : g_bad_win
      $error("cs_approx_avg_win: WIN must be in 2..32");
    end
    if (MAX_Y >= (longint'(1) << OW)) begin : g_bad_ow
      $error("cs_approx_avg_win: OW too narrow for the largest output");
    end
  endgenerate

  logic [DW-1:0] win [WIN];
  logic [SW-1:0] sum;
  logic [CW-1:0] fill;
  logic [CW-1:0] fill_nxt;
  logic          pend;
  logic          accept;
  logic [DW-1:0] appr;
  logic [SW:0]   total;
  logic [SW:0]   shifted;
  logic [OW-1:0] y_nxt;

  // clr always wins over a simultaneous sample.
  assign accept   = in_valid & ~clr;
  assign fill_nxt = (fill == WIN_C) ? fill : fill + 1'b1;

  // Window shift register: win[0] is newest, win[WIN-1] is the sample about to drop out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIN; i++) win[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < WIN; i++) win[i] <= '0;
    end else if (accept) begin
      win[0] <= X;
      for (int i = 1; i < WIN; i++) win[i] <= win[i-1];
    end
  end

  // Running sum, fill count and stage-2 request. Unfilled slots hold 0, so
  // subtracting the outgoing slot is correct even before the window is full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum  <= '0;
      fill <= '0;
      pend <= 1'b0;
    end else if (clr) begin
      sum  <= '0;
      fill <= '0;
      pend <= 1'b0;
    end else if (accept) begin
      sum  <= sum + SW'(X) - SW'(win[WIN-1]);
      fill <= fill_nxt;
      pend <= (fill_nxt == WIN_C);
    end else begin
      pend <= 1'b0;
    end
  end

  // Divider-free mean compare: x <= mean  <=>  x*WIN <= sum (and likewise for >=).
  // Floor starts from 0 and ceil from all-ones; both sets are never empty, so the
  // seed is always replaced by (or equal to) a real window sample.
  always_comb begin
    appr = mode ? '1 : '0;
    for (int i = 0; i < WIN; i++) begin
      if (!mode && ((SW'(win[i]) * WIN_S) <= sum) && (win[i] >= appr)) appr = win[i];
      if (mode && ((SW'(win[i]) * WIN_S) >= sum) && (win[i] <= appr)) appr = win[i];
    end
    total   = {1'b0, sum} + ((SW + 1)'(appr) * WIN_S1);
    shifted = total >> SHIFT;
    y_nxt   = OW'(shifted);
  end

  // Output register: Y only moves on a result, otherwise holds until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      Y         <= '0;
    end else begin
      out_valid <= pend;
      if (pend) Y <= y_nxt;
    end
  end

endmodule

// File: tb/tb_cs_approx_avg_win.sv
// Directed bench for cs_approx_avg_win: WIN=9 instance plus a WIN=16 instance.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// Expected values are hand-computed from the window contents.
module tb_cs_approx_avg_win;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] X = '0;
  logic       mode = 1'b0;
  logic       out_valid;
  logic [9:0] Y;

  logic       clr2 = 1'b0;
  logic       v2 = 1'b0;
  logic [7:0] x2 = '0;
  logic       m2 = 1'b0;
  logic       ov2;
  logic [9:0] y2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cs_approx_avg_win #(.DW(8), .WIN(9), .SHIFT(3), .OW(10)) dut (
    .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .X(X), .mode(mode),
    .out_valid(out_valid), .Y(Y)
  );

  cs_approx_avg_win #(.DW(8), .WIN(16), .SHIFT(4), .OW(10)) dut16 (
    .clk(clk), .reset(reset), .clr(clr2), .in_valid(v2), .X(x2), .mode(m2),
    .out_valid(ov2), .Y(y2)
  );

  task automatic drive(input logic v, input logic [7:0] x, input logic c, input logic m);
    in_valid = v;
    X        = x;
    clr      = c;
    mode     = m;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ov got %b want 0", out_valid); end
    n_cmp++;
    if (Y !== 10'h000) begin n_bad++; $display("FAIL reset_y got %h want 000", Y); end
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // 1..12 back-to-back: first result after the 9th sample, one per cycle thereafter.
  task automatic test_back_to_back;
    logic [9:0] exp_y [4];
    exp_y[0] = 10'h00B; exp_y[1] = 10'h00D; exp_y[2] = 10'h00F; exp_y[3] = 10'h012;
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_fill%0d ov got %b want 0", i, out_valid); end
    end
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1'b1, 8'(10 + i), 1'b0, 1'b0);
      else       drive(1'b0, 8'h00, 1'b0, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_res%0d ov got %b want 1", i, out_valid); end
      n_cmp++;
      if (Y !== exp_y[i]) begin n_bad++; $display("FAIL b2b_res%0d y got %h want %h", i, Y, exp_y[i]); end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0 || Y !== 10'h012) begin
      n_bad++; $display("FAIL b2b_hold ov=%b y=%h want ov=0 y=012", out_valid, Y);
    end
  endtask

  // clr together with a sample: sample dropped, Y held, nine fresh samples needed.
  task automatic test_clr;
    drive(1'b1, 8'd200, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0 || Y !== 10'h012) begin
      n_bad++; $display("FAIL clr_hold ov=%b y=%h want ov=0 y=012", out_valid, Y);
    end
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 8'd7, 1'b0, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL clr_refill%0d ov got %b want 0", i, out_valid); end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || Y !== 10'h00F) begin
      n_bad++; $display("FAIL clr_result ov=%b y=%h want ov=1 y=00F", out_valid, Y);
    end
  endtask

  // Eight zeros then 10: floor picks 0 (Y=1), ceil picks 10 (Y=0xC).
  task automatic test_floor_ceil;
    logic [9:0] exp_y [2];
    exp_y[0] = 10'h001; exp_y[1] = 10'h00C;
    for (int m = 0; m < 2; m++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) drive(1'b1, 8'h00, 1'b0, 1'b0);
      drive(1'b1, 8'd10, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'(m));
      n_cmp++;
      if (out_valid !== 1'b1 || Y !== exp_y[m]) begin
        n_bad++; $display("FAIL mode%0d ov=%b y=%h want ov=1 y=%h", m, out_valid, Y, exp_y[m]);
      end
    end
  endtask

  // Full-scale window then sliding zeros in, alternating mode at stage 2.
  task automatic test_max_slide;
    logic [9:0] exp_y [3];
    logic       mo [3];
    exp_y[0] = 10'h0FF; exp_y[1] = 10'h1FE; exp_y[2] = 10'h0BF;
    mo[0] = 1'b0; mo[1] = 1'b1; mo[2] = 1'b0;
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) drive(1'b1, 8'hFF, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || Y !== 10'h23D) begin
      n_bad++; $display("FAIL max_ff ov=%b y=%h want ov=1 y=23D", out_valid, Y);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h00, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b0, mo[i]);
      n_cmp++;
      if (out_valid !== 1'b1 || Y !== exp_y[i]) begin
        n_bad++; $display("FAIL slide%0d ov=%b y=%h want ov=1 y=%h", i, out_valid, Y, exp_y[i]);
      end
    end
  endtask

  // 1..9 with an idle cycle after each sample: same result as the gapless run.
  task automatic test_gaps;
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      if (i < 9) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL gap%0d ov got %b want 0", i, out_valid); end
      end
    end
    n_cmp++;
    if (out_valid !== 1'b1 || Y !== 10'h00B) begin
      n_bad++; $display("FAIL gap_result ov=%b y=%h want ov=1 y=00B", out_valid, Y);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL gap_pulse ov got %b want 0", out_valid); end
  endtask

  // Async reset between the accept edge and the result edge: result lost, refill from 0.
  task automatic test_reset_mid;
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) drive(1'b1, 8'd3, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || Y !== 10'h000) begin
      n_bad++; $display("FAIL rst_async ov=%b y=%h want ov=0 y=000", out_valid, Y);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0 || Y !== 10'h000) begin
      n_bad++; $display("FAIL rst_lost ov=%b y=%h want ov=0 y=000", out_valid, Y);
    end
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 8'd4, 1'b0, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_refill%0d ov got %b want 0", i, out_valid); end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || Y !== 10'h009) begin
      n_bad++; $display("FAIL rst_result ov=%b y=%h want ov=1 y=009", out_valid, Y);
    end
  endtask

  // WIN=16, SHIFT=4: sixteen 0x80 gives 0x100 in both modes.
  task automatic test_win16;
    for (int i = 0; i < 16; i++) begin
      v2 = 1'b1; x2 = 8'h80; m2 = 1'b0;
      @(posedge clk);
      #1;
      if (i == 14) begin
        n_cmp++;
        if (ov2 !== 1'b0) begin n_bad++; $display("FAIL w16_early ov got %b want 0", ov2); end
      end
    end
    for (int m = 0; m < 2; m++) begin
      v2 = (m == 0) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      v2 = 1'b0; m2 = 1'(m);
      if (m == 1) begin
        @(posedge clk);
        #1;
      end
      n_cmp++;
      if (ov2 !== 1'b1 || y2 !== 10'h100) begin
        n_bad++; $display("FAIL w16_mode%0d ov=%b y=%h want ov=1 y=100", m, ov2, y2);
      end
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_clr;
    test_floor_ceil;
    test_max_slide;
    test_gaps;
    test_reset_mid;
    test_win16;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
